// File: rtl/sram_pkg.sv
// Shared types and default widths for the SRAM burst sequencer slice.
package sram_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } state_e;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO holding read beats ({last, data}) for the consumer.
module sram_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 9,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/sram_burst_sequencer.sv
// Burst command front-end: turns read/write bursts into one-beat-per-cycle
// SRAM controller strobes and returns read beats through a credit-limited FIFO.
module sram_burst_sequencer
    import sram_pkg::*;
#(
    parameter int ADDR_W    = sram_pkg::ADDR_W,
    parameter int DATA_W    = sram_pkg::DATA_W,
    parameter int LEN_W     = sram_pkg::LEN_W,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_data_in,
    output logic              sram_we,
    output logic              sram_re,
    input  logic [DATA_W-1:0] sram_data_out,
    output logic              busy
);

    localparam int CW = $clog2(RSP_DEPTH);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] sram_din_q, sram_din_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              re_last_q, re_last_d;
    logic              pend_q, pend_last_q;
    logic              cmd_rdy, wr_rdy;
    logic              in_flight, pop, empty, full;
    logic [CW:0]       count;
    logic [CW+1:0]     occ;
    logic              credit_ok;
    logic [DATA_W:0]   fifo_dout;

    assign in_flight = re_q | pend_q;
    assign pop       = rsp_valid & rsp_ready;
    // Beats already owed to the FIFO count against its space; a pop this cycle frees one.
    assign occ       = (CW+2)'(count) + (CW+2)'(re_q) + (CW+2)'(pend_q) - (CW+2)'(pop);
    assign credit_ok = (occ < (CW+2)'(RSP_DEPTH));

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        len_d       = len_q;
        addr_d      = addr_q;
        sram_addr_d = sram_addr_q;
        sram_din_d  = sram_din_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        re_last_d   = 1'b0;
        cmd_rdy     = 1'b0;
        wr_rdy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_rdy = 1'b1;
                if (cmd_valid) begin
                    state_d = cmd_write ? WRITE : READ;
                    beat_d  = '0;
                    len_d   = cmd_len;
                    addr_d  = cmd_addr;
                end
            end
            WRITE: begin
                wr_rdy = 1'b1;
                if (wr_valid) begin
                    we_d        = 1'b1;
                    sram_addr_d = addr_q;
                    sram_din_d  = wr_data;
                    addr_d      = addr_q + ADDR_W'(1);
                    beat_d      = beat_q + LEN_W'(1);
                    if (beat_q == len_q) state_d = IDLE;
                end
            end
            READ: begin
                if (credit_ok) begin
                    re_d        = 1'b1;
                    re_last_d   = (beat_q == len_q);
                    sram_addr_d = addr_q;
                    addr_d      = addr_q + ADDR_W'(1);
                    beat_d      = beat_q + LEN_W'(1);
                    if (beat_q == len_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!in_flight) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            sram_addr_q <= '0;
            sram_din_q  <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            re_last_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            sram_addr_q <= sram_addr_d;
            sram_din_q  <= sram_din_d;
            we_q        <= we_d;
            re_q        <= re_d;
            re_last_q   <= re_last_d;
            pend_q      <= re_q;
            pend_last_q <= re_last_q;
        end
    end

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .W     (DATA_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pend_q),
        .din_i   ({pend_last_q, sram_data_out}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign cmd_ready    = cmd_rdy & ~rst;
    assign wr_ready     = wr_rdy & ~rst;
    assign rsp_valid    = ~empty;
    assign rsp_data     = fifo_dout[DATA_W-1:0];
    assign rsp_last     = rsp_valid & fifo_dout[DATA_W];
    assign sram_address = sram_addr_q;
    assign sram_data_in = sram_din_q;
    assign sram_we      = we_q;
    assign sram_re      = re_q;
    assign busy         = (state_q != IDLE) | rsp_valid | in_flight;

    logic unused_full;
    assign unused_full = full;

endmodule
